// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int DRAIN_CYCLES_DEF = 3;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is still fetching
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ID_EX_MemRd,
    input  logic [4:0] ID_EX_Rt,
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    input  logic       IF_ID_UsesRt,
    output logic       lu
);
    assign lu = ID_EX_MemRd && ID_EX_Rt != REG_ZERO &&
                (ID_EX_Rt == IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt == IF_ID_Rt));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/freeze/halt controller; PIPE_STALL_STATS_EN adds stall_cnt and flush_cnt
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_EX_MemRd,
    input  logic [4:0]  ID_EX_Rt,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        IF_ID_UsesRt,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    input  logic        halt,
    output logic        pc_we,
    output logic        if_id_we,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_mem_we,
`ifdef PIPE_STALL_STATS_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        halted
);
    state_t      state;
    logic [31:0] cnt;
    logic        lu, mw, freeze;

    load_use_detect u_lu (
        .ID_EX_MemRd (ID_EX_MemRd),
        .ID_EX_Rt    (ID_EX_Rt),
        .IF_ID_Rs    (IF_ID_Rs),
        .IF_ID_Rt    (IF_ID_Rt),
        .IF_ID_UsesRt(IF_ID_UsesRt),
        .lu          (lu)
    );

    assign mw     = dmem_req && !dmem_ack;
    assign freeze = (state == MEM_WAIT) ? !dmem_ack : mw;

    // enables and squash controls, by priority: reset, halted, freeze, drain, branch, load-use
    always_comb begin
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        ex_mem_we    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;
        if (rst || state == HALTED || freeze) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            ex_mem_we = 1'b0;
            halted    = !rst && state == HALTED;
        end else if (state == DRAIN) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (lu) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // state transitions and drain countdown; a halt only starts draining from an otherwise quiet RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == RUN) begin
            if (mw)
                state <= MEM_WAIT;
            else if (!branch_taken && !lu && halt) begin
                state <= DRAIN;
                cnt   <= 32'(DRAIN_CYCLES - 1);
            end
        end else if (state == MEM_WAIT) begin
            if (dmem_ack)
                state <= RUN;
        end else if (state == DRAIN && !mw) begin
            if (cnt == '0)
                state <= HALTED;
            else
                cnt <= cnt - 32'd1;
        end
    end

`ifdef PIPE_STALL_STATS_EN
    logic active;
    assign active = state == RUN || state == MEM_WAIT;

    // stall and flush statistics, counted only while the pipeline is live
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (active && !pc_we)
                stall_cnt <= stall_cnt + 32'd1;
            if (active && if_id_flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scoreboard bench for pipeline_ctrl; covers stats when PIPE_STALL_STATS_EN is defined
module tb_pipeline_ctrl;
    // expected {pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, halted}
    localparam logic [5:0] RST = 6'b000000;
    localparam logic [5:0] DEF = 6'b110010;
    localparam logic [5:0] LU  = 6'b000110;
    localparam logic [5:0] BR  = 6'b111110;
    localparam logic [5:0] FRZ = 6'b000000;
    localparam logic [5:0] DRN = 6'b011010;
    localparam logic [5:0] HLT = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ID_EX_MemRd = 1'b0, IF_ID_UsesRt = 1'b0, branch_taken = 1'b0;
    logic dmem_req = 1'b0, dmem_ack = 1'b0, halt = 1'b0;
    logic [4:0] ID_EX_Rt = '0, IF_ID_Rs = '0, IF_ID_Rt = '0;
    logic pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, halted;
`ifdef PIPE_STALL_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif
    int tests = 0;
    int fails = 0;
    string      tags[$];
    logic [5:0] exps[$];

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .ID_EX_MemRd(ID_EX_MemRd), .ID_EX_Rt(ID_EX_Rt),
        .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_UsesRt(IF_ID_UsesRt),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .halt(halt),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
`ifdef PIPE_STALL_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic mrd, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic br,
                        input logic rq, input logic ak, input logic hl, input logic [5:0] e);
        @(posedge clk);
        #1;
        rst = r; ID_EX_MemRd = mrd; ID_EX_Rt = ert; IF_ID_Rs = rs; IF_ID_Rt = rt;
        IF_ID_UsesRt = ur; branch_taken = br; dmem_req = rq; dmem_ack = ak; halt = hl;
        tags.push_back(tag);
        exps.push_back(e);
    endtask

    task automatic idle(input string tag, input logic [5:0] e);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    endtask

    always @(negedge clk)
        if (exps.size() > 0)
            check(tags.pop_front(),
                  {26'd0, pc_we, if_id_we, if_id_flush, id_ex_bubble, ex_mem_we, halted},
                  {26'd0, exps.pop_front()});

    initial begin
        step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
        step("reset2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
        idle("run_after_rst", DEF);
        step("lu_rs", 0, 1, 5, 5, 2, 1, 0, 0, 0, 0, LU);
        idle("lu_release", DEF);
        step("lu_rt", 0, 1, 7, 1, 7, 1, 0, 0, 0, 0, LU);
        step("no_lu_imm", 0, 1, 5, 0, 5, 0, 0, 0, 0, 0, DEF);
        step("no_lu_r0", 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, DEF);
        step("br_over_lu", 0, 1, 5, 5, 2, 1, 1, 0, 0, 0, BR);
        step("ack_no_req", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, DEF);
        for (int i = 0; i < 3; i++)
            step("mem_freeze", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, FRZ);
        step("mem_ack_br", 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, BR);
        idle("mem_back_run", DEF);
        idle("mw_halt_ignored", DEF);
        step("mem_freeze_lu", 0, 1, 3, 3, 0, 0, 0, 1, 0, 0, FRZ);
        step("mem_ack_lu", 0, 1, 3, 3, 0, 0, 0, 1, 1, 0, LU);
        idle("after_ack_lu", DEF);
        step("halt_cycle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF);
        for (int i = 0; i < 3; i++)
            step("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, DRN);
        step("halted", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, HLT);
        idle("halted_hold", HLT);
        step("rst_halted", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
        idle("run_after_halt", DEF);
        step("halt2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF);
        idle("drain2_a", DRN);
        step("drain_freeze", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ);
        step("drain_br_ign", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, DRN);
        idle("drain2_c", DRN);
        idle("halted2", HLT);
        step("halt3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
        step("halt3_go", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, DEF);
        idle("drain3", DRN);
        step("rst_in_drain", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
        idle("run_after_drain_rst", DEF);
        step("mw_a", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ);
        step("mw_b", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ);
        step("rst_in_mw", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, RST);
        idle("run_after_mw_rst", DEF);
        step("stat_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST);
        step("stat_lu1", 0, 1, 4, 4, 0, 0, 0, 0, 0, 0, LU);
        idle("stat_gap", DEF);
        step("stat_lu2", 0, 1, 9, 1, 9, 1, 0, 0, 0, 0, LU);
        step("stat_br", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, BR);
        idle("stat_end", DEF);
        @(negedge clk);
        #1;
`ifdef PIPE_STALL_STATS_EN
        check("stall_cnt", stall_cnt, 32'd2);
        check("flush_cnt", flush_cnt, 32'd1);
`endif
        check("queue_empty", 32'(exps.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
